// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU among NREQ requesters.
// Each cycle the oldest-by-round-robin pending request is driven onto the ALU.
// Its result is captured into a one-deep response slot together with the
// requester index.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (req_ready one-hot or zero)
//   req_a/req_b/req_op    packed per-requester operands and op (slice i = requester i)
//   alu_a/alu_b/alu_op    operands and op to the shared ALU (combinational mux)
//   alu_res               ALU result, combinational from alu_a/alu_b/alu_op
//   rsp_valid/rsp_ready   response slot handshake
//   rsp_id/rsp_res        owner index and captured result
module alu_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*4-1:0]    req_op,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [3:0]           alu_op,
    input  logic [31:0]          alu_res,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_res
);

    localparam int unsigned DW = 32;
    localparam int unsigned OW = 4;

    logic           r_rsp_valid;
    logic [IDW-1:0] r_rsp_id;
    logic [DW-1:0]  r_rsp_res;
    logic [IDW-1:0] r_ptr;

    logic           w_found;
    logic [IDW-1:0] w_win;
    logic           w_can_accept;
    logic           w_accept;
    logic [IDW-1:0] w_ptr_nxt;

    // Round-robin pick: first valid at or above ptr, else first valid from 0.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && (IDW'(i) >= r_ptr)) begin
                w_found = 1'b1;
                w_win   = IDW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i]) begin
                w_found = 1'b1;
                w_win   = IDW'(i);
            end
        end
    end

    // Slot can take a new result if empty or being drained this cycle; never in reset.
    assign w_can_accept = rst_n && (!r_rsp_valid || rsp_ready);
    assign w_accept     = w_found && w_can_accept;
    assign w_ptr_nxt    = (w_win == IDW'(NREQ - 1)) ? '0 : IDW'(w_win + 1'b1);

    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready[i] = w_accept && (w_win == IDW'(i));
        end
    end

    // ALU drive follows the winner even when stalled; requester 0 when idle.
    always_comb begin
        alu_a  = req_a[DW-1:0];
        alu_b  = req_b[DW-1:0];
        alu_op = req_op[OW-1:0];
        for (int unsigned i = 1; i < NREQ; i++) begin
            if (w_found && (w_win == IDW'(i))) begin
                alu_a  = req_a[i*DW +: DW];
                alu_b  = req_b[i*DW +: DW];
                alu_op = req_op[i*OW +: OW];
            end
        end
    end

    // Response slot and pointer; accept wins over drain so back-to-back results flow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_res   <= '0;
            r_ptr       <= '0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_win;
            r_rsp_res   <= alu_res;
            r_ptr       <= w_ptr_nxt;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_res   = r_rsp_res;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: an NREQ=2 and an NREQ=4 instance, each
// checked every cycle against a round-robin model plus literal expectations.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Small reference ALU shared by both instances.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return 32'h0;
        endcase
    endfunction

    // NREQ=2 instance
    logic [1:0]  v2, rdy2;
    logic [63:0] a2, b2;
    logic [7:0]  op2;
    logic [31:0] aa2, ab2, res2, rres2;
    logic [3:0]  ao2;
    logic        rv2, rr2;
    logic [1:0]  rid2;
    assign res2 = alu_f(aa2, ab2, ao2);

    alu_arbiter #(.NREQ(2), .IDW(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v2), .req_ready(rdy2),
        .req_a(a2), .req_b(b2), .req_op(op2),
        .alu_a(aa2), .alu_b(ab2), .alu_op(ao2), .alu_res(res2),
        .rsp_valid(rv2), .rsp_ready(rr2), .rsp_id(rid2), .rsp_res(rres2)
    );

    // NREQ=4 instance
    logic [3:0]   v4, rdy4;
    logic [127:0] a4, b4;
    logic [15:0]  op4;
    logic [31:0]  aa4, ab4, res4, rres4;
    logic [3:0]   ao4;
    logic         rv4, rr4;
    logic [1:0]   rid4;
    assign res4 = alu_f(aa4, ab4, ao4);

    alu_arbiter #(.NREQ(4), .IDW(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v4), .req_ready(rdy4),
        .req_a(a4), .req_b(b4), .req_op(op4),
        .alu_a(aa4), .alu_b(ab4), .alu_op(ao4), .alu_res(res4),
        .rsp_valid(rv4), .rsp_ready(rr4), .rsp_id(rid4), .rsp_res(rres4)
    );

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Model state per instance: slot contents and round-robin pointer.
    int          m_ptr [2];
    logic        m_v   [2];
    logic [1:0]  m_id  [2];
    logic [31:0] m_res [2];

    task automatic model_check(input int inst, input int n,
                               input logic [3:0] v, input logic [127:0] a,
                               input logic [127:0] b, input logic [15:0] op,
                               input logic rr, input logic [3:0] g_rdy,
                               input logic [31:0] g_a, input logic [31:0] g_b,
                               input logic [3:0] g_op, input logic g_v,
                               input logic [1:0] g_id, input logic [31:0] g_res);
        int win;
        bit can;
        logic [3:0] e_rdy;
        logic [31:0] e_a, e_b;
        logic [3:0] e_op;
        if (!rst_n) begin
            m_ptr[inst] = 0; m_v[inst] = 1'b0; m_id[inst] = 2'd0; m_res[inst] = 32'd0;
        end
        can = rst_n && (!m_v[inst] || rr);
        win = -1;
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (m_ptr[inst] + k) % n;
            if (win < 0 && v[idx]) win = idx;
        end
        e_rdy = (can && win >= 0) ? 4'(1 << win) : 4'd0;
        e_a  = (win >= 0) ? a[win*32 +: 32] : a[31:0];
        e_b  = (win >= 0) ? b[win*32 +: 32] : b[31:0];
        e_op = (win >= 0) ? op[win*4 +: 4] : op[3:0];
        cmp($sformatf("n%0d.req_ready", n), 32'(g_rdy), 32'(e_rdy));
        cmp($sformatf("n%0d.alu_a", n), g_a, e_a);
        cmp($sformatf("n%0d.alu_b", n), g_b, e_b);
        cmp($sformatf("n%0d.alu_op", n), 32'(g_op), 32'(e_op));
        cmp($sformatf("n%0d.rsp_valid", n), 32'(g_v), 32'(m_v[inst]));
        cmp($sformatf("n%0d.rsp_id", n), 32'(g_id), 32'(m_id[inst]));
        cmp($sformatf("n%0d.rsp_res", n), g_res, m_res[inst]);
        // Advance to the state the coming rising edge must produce.
        if (rst_n) begin
            if (e_rdy != 4'd0) begin
                m_v[inst]   = 1'b1;
                m_id[inst]  = 2'(win);
                m_res[inst] = alu_f(e_a, e_b, e_op);
                m_ptr[inst] = (win + 1) % n;
            end else if (m_v[inst] && rr) begin
                m_v[inst] = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        model_check(0, 2, {2'b0, v2}, {64'b0, a2}, {64'b0, b2}, {8'b0, op2}, rr2,
                    {2'b0, rdy2}, aa2, ab2, ao2, rv2, rid2, rres2);
        model_check(1, 4, v4, a4, b4, op4, rr4, rdy4, aa4, ab4, ao4, rv4, rid4, rres4);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        v2 = '0; a2 = '0; b2 = '0; op2 = '0; rr2 = 1'b0;
        v4 = '0; a4 = '0; b4 = '0; op4 = '0; rr4 = 1'b0;
        step(); step();
        cmp("reset.rsp_valid", 32'(rv2), 32'd0);
        cmp("reset.req_ready", 32'(rdy2), 32'd0);
        rst_n = 1'b1;

        // Single request on requester 0: 5 + 7.
        v2 = 2'b01; a2[31:0] = 32'd5; b2[31:0] = 32'd7; op2[3:0] = 4'd0; rr2 = 1'b1;
        #1 cmp("single.ready", 32'(rdy2), 32'd1);
        step();
        v2 = 2'b00;
        #1;
        cmp("single.rsp_valid", 32'(rv2), 32'd1);
        cmp("single.rsp_id", 32'(rid2), 32'd0);
        cmp("single.rsp_res", rres2, 32'd12);

        // Fairness: ptr is now 1, so requester 1 goes first, then alternation.
        v2 = 2'b11;
        a2[31:0] = 32'd3;     b2[31:0] = 32'd5;     op2[3:0] = 4'd1;
        a2[63:32] = 32'hF0;   b2[63:32] = 32'h3C;   op2[7:4] = 4'd2;
        #1 cmp("rr.first_grant", 32'(rdy2), 32'd2);
        for (int k = 0; k < 4; k++) begin
            step();
            #1;
            cmp("rr.rsp_valid", 32'(rv2), 32'd1);
            cmp("rr.rsp_id", 32'(rid2), (k % 2 == 0) ? 32'd1 : 32'd0);
            cmp("rr.rsp_res", rres2, (k % 2 == 0) ? 32'h30 : 32'hFFFF_FFFE);
        end

        // Backpressure: slot holds requester 0's result, requester 1 waits.
        rr2 = 1'b0; v2 = 2'b10;
        for (int k = 0; k < 3; k++) begin
            #1;
            cmp("bp.ready", 32'(rdy2), 32'd0);
            cmp("bp.rsp_id", 32'(rid2), 32'd0);
            cmp("bp.rsp_res", rres2, 32'hFFFF_FFFE);
            step();
        end
        rr2 = 1'b1;
        #1 cmp("bp.release_ready", 32'(rdy2), 32'd2);
        step();
        v2 = 2'b00;
        #1;
        cmp("bp.after_id", 32'(rid2), 32'd1);
        cmp("bp.after_res", rres2, 32'h30);
        step();
        cmp("bp.drained", 32'(rv2), 32'd0);

        // Asynchronous reset with the slot full (5 + 7 = 12 held, ptr then 1).
        v2 = 2'b01; a2[31:0] = 32'd5; b2[31:0] = 32'd7; op2[3:0] = 4'd0; rr2 = 1'b0;
        step();
        v2 = 2'b00;
        #1;
        cmp("rst.pre_res", rres2, 32'd12);
        #1 rst_n = 1'b0;
        #1;
        cmp("rst.async_valid", 32'(rv2), 32'd0);
        cmp("rst.async_res", rres2, 32'd0);
        step(); step();
        rst_n = 1'b1;
        v2 = 2'b11; rr2 = 1'b1;
        #1 cmp("rst.tie_to_0", 32'(rdy2), 32'd1);
        step();

        // Idle: ALU mirrors requester 0, no grants, ptr unchanged (=1).
        v2 = 2'b00;
        a2[31:0] = 32'hDEAD_BEEF; b2[31:0] = 32'h1234_5678; op2[3:0] = 4'd4;
        repeat (10) step();
        cmp("idle.alu_a", aa2, 32'hDEAD_BEEF);
        cmp("idle.alu_b", ab2, 32'h1234_5678);
        cmp("idle.ready", 32'(rdy2), 32'd0);
        cmp("idle.rsp_valid", 32'(rv2), 32'd0);
        v2 = 2'b11;
        #1 cmp("idle.ptr_kept", 32'(rdy2), 32'd2);
        step();
        v2 = 2'b00;

        // Wrap-around on NREQ=4: accept requester 2 so ptr becomes 3.
        rr4 = 1'b1; v4 = 4'b0100;
        a4[95:64] = 32'd8;  b4[95:64] = 32'd1;  op4[11:8] = 4'd3;
        a4[63:32] = 32'd1;  b4[63:32] = 32'd2;  op4[7:4] = 4'd0;
        a4[127:96] = 32'd10; b4[127:96] = 32'd4; op4[15:12] = 4'd1;
        #1 cmp("wrap.grant2", 32'(rdy4), 32'd4);
        step();
        v4 = 4'b1010;
        #1;
        cmp("wrap.rsp2_res", rres4, 32'd9);
        cmp("wrap.grant3", 32'(rdy4), 32'd8);
        step();
        #1;
        cmp("wrap.rsp3_id", 32'(rid4), 32'd3);
        cmp("wrap.rsp3_res", rres4, 32'd6);
        cmp("wrap.grant1", 32'(rdy4), 32'd2);
        step();
        v4 = 4'b0000;
        #1;
        cmp("wrap.rsp1_id", 32'(rid4), 32'd1);
        cmp("wrap.rsp1_res", rres4, 32'd3);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational S1 ALU between up to four requesters (integer pipe, address generator, multi-cycle sequencers) through a one-deep registered response slot. Each cycle it grants one pending request by round-robin, drives it onto the ALU, and captures the result with the requester's ID. Results are presented one cycle after acceptance and held until the consumer takes them.

## Interface

Parameters:
- NREQ, 2: number of requesters; legal values are 2..4.
- IDW, 2: width of rsp_id; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  the single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*32  operand A; slice i belongs to requester i.
- req_b  in  NREQ*32  operand B; slice i.
- req_op  in  NREQ*4  ALU op; slice i.
- alu_a  out  32  operand A to the ALU.
- alu_b  out  32  operand B to the ALU.
- alu_op  out  4  op to the ALU.
- alu_res  in  32  ALU result (combinational from alu_a/alu_b/alu_op).
- rsp_valid  out  1  response slot holds a result.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  IDW  index of the requester that owns rsp_res.
- rsp_res  out  32  captured ALU result.

## Operation

- State: response slot (rsp_valid, rsp_id, rsp_res) and round-robin pointer ptr (range 0..NREQ-1).
- can_accept = !rsp_valid || rsp_ready.
- Grant: scan from ptr upward, wrapping modulo NREQ; the first i with req_valid[i] wins.
- req_ready[i] = can_accept && (i is the winner). All bits are 0 when no request is valid or can_accept=0.
- ALU drive:
  - If a winner exists, alu_a/alu_b/alu_op = the winner's slices, whether or not can_accept is set.
  - Otherwise they hold the requester-0 slices, so the ALU inputs never float.
- Accept (a req_valid[i] && req_ready[i] handshake):
  - Load rsp_res <= alu_res and rsp_id <= i.
  - Set rsp_valid <= 1.
  - Set ptr <= (i+1) mod NREQ.
- Drain without accept (rsp_valid && rsp_ready, no accept that cycle): rsp_valid <= 0.
- Simultaneous drain and accept: the slot reloads with the new result and rsp_valid stays 1. This gives one result per cycle.
- ptr changes only on accept. An unserved requester waits at most NREQ-1 accepts.
- Width and op semantics belong to the ALU. This block passes operands and op through unmodified and never alters alu_res.
- A requester may not change its slices while valid is high and ready is low. This is a bench assertion; the block does not check it.
- Reset (asynchronous assert, at any time including with the slot full):
  - rsp_valid=0, rsp_id=0, rsp_res=0, ptr=0.
  - req_ready=0 while rst_n=0.
  - A pending result is discarded.

## Timing

- Latency: accept in cycle N gives rsp_valid=1 with the result in cycle N+1.
- Throughput: 1 result per cycle while rsp_ready is held high.
- Combinational paths:
  - rsp_ready to req_ready, one gate level.
  - req_* through the mux to alu_* and back through alu_res to the slot D input. This is the critical path.
- No combinational path exists from req_valid to rsp_*.
- Backpressure: with rsp_ready=0 and the slot full, all req_ready bits are 0. rsp_* hold stable until the drain.

## Test plan

- Single request: NREQ=2. req_valid=01, a=5, b=7, op=0 in cycle 0. Expect req_ready=01 in cycle 0; in cycle 1, rsp_valid=1, rsp_id=0, rsp_res=12, and ptr=1.
- Round-robin fairness: both requesters valid continuously, rsp_ready=1. Requester 0 subtracts a=3, b=5, op=1; requester 1 does a=0xF0 AND b=0x3C, op=2. Expect rsp_id to alternate 0,1,0,1 with results 0xFFFFFFFE and 0x30, one response per cycle.
- Backpressure: slot full with rsp_ready=0 for 3 cycles while requester 1 is valid. Expect req_ready=0 and rsp_* unchanged. When rsp_ready goes to 1, expect requester 1 accepted in the same cycle and its result in the next cycle.
- Wrap-around: NREQ=4 with ptr=3 and requesters 1 and 3 valid. Expect 3 granted first, ptr then 0, then 1 granted.
- Reset mid-operation: assert rst_n=0 asynchronously with the slot full (rsp_res=12). Expect rsp_valid=0 and rsp_res=0 immediately, without waiting for a clock edge. After release, expect ptr=0, so requester 0 wins a tie.
- Idle: no req_valid for 10 cycles. Expect req_ready=0, ptr unchanged, rsp_valid low, and alu_* equal to the requester-0 slices.
